// File: rtl/addition_stage5_rounding.sv
// addition_stage5_rounding: final rounding stage of the FP adder.
// Two-stage valid/ready pipeline producing the IEEE-754 result.
//
// Ports:
//   clk_in, rst_in       clock, async active-high reset
//   valid_in, ready_out  upstream handshake
//   sign_in              result sign
//   exponent_in          normalized biased exponent
//   mentissa_in          normalized stored mantissa
//   grs_in               {guard, round, sticky}
//   round_mode_in        rounding mode (ROUND_MODE_EN only)
//   valid_out, ready_in  downstream handshake
//   floating_out         {sign, exponent, mantissa}
//   overflow_out         result overflowed (rounded to Inf/max)
//   inexact_out          discarded bits were non-zero
//
// Optional feature macro: ROUND_MODE_EN
//   defined   -> round_mode_in port, RNE/RTZ/RUP/RDN
//   undefined -> RNE only
module addition_stage5_rounding #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  sign_in,
  input  logic [EXPO_WIDTH-1:0] exponent_in,
  input  logic [MENT_WIDTH-1:0] mentissa_in,
  input  logic [2:0]            grs_in,
`ifdef ROUND_MODE_EN
  input  logic [1:0]            round_mode_in,
`endif
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] floating_out,
  output logic                  overflow_out,
  output logic                  inexact_out
);

  // ---------------- pipeline enable ----------------
  logic w_en;

  assign w_en      = !valid_out || ready_in;
  assign ready_out = w_en;

  // ---------------- stage A: rounding decision ----------------
  logic w_g;
  logic w_r;
  logic w_s;
  logic w_lsb;
  logic w_special;
  logic w_any;
  logic w_rne;
  logic w_inc;
  logic w_inexact;

  assign w_g       = grs_in[2];
  assign w_r       = grs_in[1];
  assign w_s       = grs_in[0];
  assign w_lsb     = mentissa_in[0];
  assign w_special = &exponent_in;
  assign w_any     = |grs_in;
  assign w_rne     = w_g & (w_r | w_s | w_lsb);

`ifdef ROUND_MODE_EN
  logic w_mode_inc;

  always_comb begin
    w_mode_inc = 1'b0;
    unique case (round_mode_in)
      2'b00:   w_mode_inc = w_rne;
      2'b01:   w_mode_inc = 1'b0;
      2'b10:   w_mode_inc = !sign_in & w_any;
      2'b11:   w_mode_inc = sign_in & w_any;
      default: w_mode_inc = w_rne;
    endcase
  end

  // Inf/NaN must never be altered, so no increment.
  assign w_inc = w_special ? 1'b0 : w_mode_inc;
`else
  assign w_inc = w_special ? 1'b0 : w_rne;
`endif

  assign w_inexact = !w_special & w_any;

  logic                  r_va;
  logic                  r_a_sign;
  logic [EXPO_WIDTH-1:0] r_a_exp;
  logic [MENT_WIDTH-1:0] r_a_mant;
  logic                  r_a_inc;
  logic                  r_a_inexact;
  logic                  r_a_special;
`ifdef ROUND_MODE_EN
  logic [1:0]            r_a_mode;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_va        <= 1'b0;
      r_a_sign    <= 1'b0;
      r_a_exp     <= '0;
      r_a_mant    <= '0;
      r_a_inc     <= 1'b0;
      r_a_inexact <= 1'b0;
      r_a_special <= 1'b0;
`ifdef ROUND_MODE_EN
      r_a_mode    <= 2'b00;
`endif
    end else if (w_en) begin
      r_va        <= valid_in;
      r_a_sign    <= sign_in;
      r_a_exp     <= exponent_in;
      r_a_mant    <= mentissa_in;
      r_a_inc     <= w_inc;
      r_a_inexact <= w_inexact;
      r_a_special <= w_special;
`ifdef ROUND_MODE_EN
      r_a_mode    <= round_mode_in;
`endif
    end
  end

  // ---------------- stage B: apply increment ----------------
  logic [MENT_WIDTH:0]   w_sum;
  logic                  w_carry;
  logic [EXPO_WIDTH-1:0] w_exp_inc;
  logic [EXPO_WIDTH-1:0] w_exp_new;
  logic [MENT_WIDTH-1:0] w_mant_new;
  logic                  w_ovf;
  logic [EXPO_WIDTH-1:0] w_exp_fin;
  logic [MENT_WIDTH-1:0] w_mant_fin;

  assign w_sum     = {1'b0, r_a_mant}
                   + {{MENT_WIDTH{1'b0}}, r_a_inc};
  assign w_carry   = w_sum[MENT_WIDTH];
  assign w_exp_inc = r_a_exp + {{(EXPO_WIDTH-1){1'b0}}, 1'b1};

  // A carry out of the mantissa means 1.111..1 became 10.0,
  // so the fraction wraps to zero and the exponent bumps.
  assign w_exp_new  = w_carry ? w_exp_inc : r_a_exp;
  assign w_mant_new = w_carry ? '0 : w_sum[MENT_WIDTH-1:0];

  // Special inputs carry no increment, so only a real
  // rounding carry can land on the all-ones exponent.
  assign w_ovf = w_carry & (&w_exp_new) & !r_a_special;

`ifdef ROUND_MODE_EN
  logic w_toward_zero;

  assign w_toward_zero = (r_a_mode == 2'b01)
                       | ((r_a_mode == 2'b10) & r_a_sign)
                       | ((r_a_mode == 2'b11) & !r_a_sign);

  always_comb begin
    w_exp_fin  = w_exp_new;
    w_mant_fin = w_mant_new;
    unique case (1'b1)
      (w_ovf && w_toward_zero): begin
        w_exp_fin  = {{(EXPO_WIDTH-1){1'b1}}, 1'b0};
        w_mant_fin = '1;
      end
      w_ovf: begin
        w_exp_fin  = '1;
        w_mant_fin = '0;
      end
      default: begin
        w_exp_fin  = w_exp_new;
        w_mant_fin = w_mant_new;
      end
    endcase
  end
`else
  always_comb begin
    w_exp_fin  = w_exp_new;
    w_mant_fin = w_mant_new;
    unique case (1'b1)
      w_ovf: begin
        w_exp_fin  = '1;
        w_mant_fin = '0;
      end
      default: begin
        w_exp_fin  = w_exp_new;
        w_mant_fin = w_mant_new;
      end
    endcase
  end
`endif

  logic                  r_vb;
  logic [DATA_WIDTH-1:0] r_b_float;
  logic                  r_b_ovf;
  logic                  r_b_inexact;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_vb        <= 1'b0;
      r_b_float   <= '0;
      r_b_ovf     <= 1'b0;
      r_b_inexact <= 1'b0;
    end else if (w_en) begin
      r_vb        <= r_va;
      r_b_float   <= {r_a_sign, w_exp_fin, w_mant_fin};
      r_b_ovf     <= w_ovf;
      r_b_inexact <= r_a_inexact;
    end
  end

  assign valid_out    = r_vb;
  assign floating_out = r_b_float;
  assign overflow_out = r_b_ovf;
  assign inexact_out  = r_b_inexact;

endmodule

// File: tb/tb_addition_stage5_rounding.sv
// tb_addition_stage5_rounding: directed checks of the
// rounding stage, including stalls and mid-flight reset.
module tb_addition_stage5_rounding;

  logic        clk_in;
  logic        rst_in;
  logic        valid_in;
  logic        ready_out;
  logic        sign_in;
  logic [7:0]  exponent_in;
  logic [22:0] mentissa_in;
  logic [2:0]  grs_in;
`ifdef ROUND_MODE_EN
  logic [1:0]  round_mode_in;
`endif
  logic        valid_out;
  logic        ready_in;
  logic [31:0] floating_out;
  logic        overflow_out;
  logic        inexact_out;

  int n_cmp = 0;
  int n_err = 0;

  addition_stage5_rounding dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .sign_in      (sign_in),
    .exponent_in  (exponent_in),
    .mentissa_in  (mentissa_in),
    .grs_in       (grs_in),
`ifdef ROUND_MODE_EN
    .round_mode_in(round_mode_in),
`endif
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .floating_out (floating_out),
    .overflow_out (overflow_out),
    .inexact_out  (inexact_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic test_reset();
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid got %b want 0", valid_out);
    end
    n_cmp++;
    if (floating_out !== 32'h0) begin
      n_err++;
      $display("FAIL reset_float got %h want 0", floating_out);
    end
    n_cmp++;
    if ({overflow_out, inexact_out} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_flags got %b%b want 00",
               overflow_out, inexact_out);
    end
    n_cmp++;
    if (ready_out !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got %b want 1", ready_out);
    end
  endtask

  // One isolated beat; result appears two edges later.
  task automatic run_one(
    input string       name,
    input logic        s,
    input logic [7:0]  e,
    input logic [22:0] m,
    input logic [2:0]  g,
    input logic [31:0] want,
    input logic        want_ovf,
    input logic        want_inx
  );
    @(negedge clk_in);
    ready_in    = 1'b1;
    valid_in    = 1'b1;
    sign_in     = s;
    exponent_in = e;
    mentissa_in = m;
    grs_in      = g;
    @(negedge clk_in);
    valid_in = 1'b0;
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL %s early_valid got %b want 0",
               name, valid_out);
    end
    @(negedge clk_in);
    n_cmp++;
    if (valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL %s valid got %b want 1", name, valid_out);
    end
    n_cmp++;
    if (floating_out !== want) begin
      n_err++;
      $display("FAIL %s result got %h want %h",
               name, floating_out, want);
    end
    n_cmp++;
    if (overflow_out !== want_ovf || inexact_out !== want_inx)
    begin
      n_err++;
      $display("FAIL %s flags got ovf=%b inx=%b want %b %b",
               name, overflow_out, inexact_out,
               want_ovf, want_inx);
    end
  endtask

  task automatic test_rounding();
    run_one("rne_tie_even", 0, 8'h80, 23'h000000, 3'b100,
            32'h40000000, 0, 1);
    run_one("rne_tie_odd", 0, 8'h80, 23'h000001, 3'b100,
            32'h40000002, 0, 1);
    run_one("rne_tie_odd3", 0, 8'h80, 23'h000003, 3'b100,
            32'h40000004, 0, 1);
    run_one("rne_below", 0, 8'h80, 23'h000000, 3'b011,
            32'h40000000, 0, 1);
    run_one("exact", 0, 8'h80, 23'h000005, 3'b000,
            32'h40000005, 0, 0);
    run_one("carry_out", 0, 8'h7F, 23'h7FFFFF, 3'b110,
            32'h40000000, 0, 1);
    run_one("denorm_carry", 0, 8'h00, 23'h7FFFFF, 3'b101,
            32'h00800000, 0, 1);
    run_one("overflow", 1, 8'hFE, 23'h7FFFFF, 3'b111,
            32'hFF800000, 1, 1);
    run_one("special_nan", 0, 8'hFF, 23'h400000, 3'b111,
            32'h7FC00000, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [4];
    logic        bs [4];
    logic [7:0]  be [4];
    logic [22:0] bm [4];
    logic [2:0]  bg [4];
    logic [31:0] held;
    logic        stalled;
    int          in_i;
    int          out_i;
    bs[0] = 0; be[0] = 8'h80; bm[0] = 23'h0;  bg[0] = 3'b100;
    want[0] = 32'h40000000;
    bs[1] = 0; be[1] = 8'h80; bm[1] = 23'h1;  bg[1] = 3'b100;
    want[1] = 32'h40000002;
    bs[2] = 0; be[2] = 8'h81; bm[2] = 23'h10; bg[2] = 3'b000;
    want[2] = 32'h40800010;
    bs[3] = 1; be[3] = 8'h82; bm[3] = 23'h7;  bg[3] = 3'b110;
    want[3] = 32'hC1000008;
    in_i    = 0;
    out_i   = 0;
    stalled = 1'b0;
    held    = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk_in);
      ready_in = !(cyc >= 3 && cyc <= 5);
      if (stalled) begin
        n_cmp++;
        if (floating_out !== held || valid_out !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_hold cyc %0d got %h/%b want %h/1",
                   cyc, floating_out, valid_out, held);
        end
      end
      if (valid_out) begin
        if (out_i >= 4) begin
          n_cmp++;
          n_err++;
          $display("FAIL b2b_extra cyc %0d got %h want none",
                   cyc, floating_out);
        end else begin
          n_cmp++;
          if (floating_out !== want[out_i]) begin
            n_err++;
            $display("FAIL b2b_order beat %0d got %h want %h",
                     out_i, floating_out, want[out_i]);
          end
          if (ready_in) out_i++;
        end
      end
      stalled = valid_out && !ready_in;
      held    = floating_out;
      valid_in = (in_i < 4);
      if (in_i < 4) begin
        sign_in     = bs[in_i];
        exponent_in = be[in_i];
        mentissa_in = bm[in_i];
        grs_in      = bg[in_i];
      end
      #1;
      if (stalled) begin
        n_cmp++;
        if (ready_out !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_ready cyc %0d got %b want 0",
                   cyc, ready_out);
        end
      end
      if (valid_in && ready_out) in_i++;
    end
    valid_in = 1'b0;
    n_cmp++;
    if (out_i !== 4 || in_i !== 4) begin
      n_err++;
      $display("FAIL b2b_count got out=%0d in=%0d want 4 4",
               out_i, in_i);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk_in);
    ready_in    = 1'b1;
    valid_in    = 1'b1;
    sign_in     = 1'b0;
    exponent_in = 8'h80;
    mentissa_in = 23'h11;
    grs_in      = 3'b000;
    @(negedge clk_in);
    mentissa_in = 23'h22;
    @(negedge clk_in);
    valid_in = 1'b0;
    n_cmp++;
    if (valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre valid got %b want 1", valid_out);
    end
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    n_cmp++;
    if (valid_out !== 1'b0 || floating_out !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid got %b/%h want 0/0",
               valid_out, floating_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      n_cmp++;
      if (valid_out !== 1'b0) begin
        n_err++;
        $display("FAIL rst_stale cyc %0d got %b want 0",
                 i, valid_out);
      end
    end
  endtask

  initial begin
    rst_in      = 1'b1;
    valid_in    = 1'b0;
    ready_in    = 1'b1;
    sign_in     = 1'b0;
    exponent_in = '0;
    mentissa_in = '0;
    grs_in      = '0;
`ifdef ROUND_MODE_EN
    round_mode_in = 2'b00;
`endif
    repeat (2) @(negedge clk_in);
    test_reset();
    rst_in = 1'b0;
    test_rounding();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
